// File: rtl/xfan_ifu_fetch_if.sv
// Fetch-unit bus: instruction-memory request/response, decode handoff and redirect.
// The master side is the fetch unit; the slave side is memory plus decode.
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif

interface xfan_ifu_fetch_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = `INSTR_SIZE
);
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/xfan_ifu_fetch.sv
// Instruction-fetch requester: credit-limited sequential fetch, in-order response queue,
// redirect handling with draining of stale in-flight responses.
module xfan_ifu_fetch #(
    parameter int                 ADDR_W     = 32,
    parameter int                 INSTR_W    = `INSTR_SIZE,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
    parameter int                 FIFO_DEPTH = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    xfan_ifu_fetch_if.master  bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

    typedef enum logic {ST_FETCH = 1'b0, ST_FLUSH = 1'b1} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [INSTR_W-1:0] data_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]  fpc_q  [FIFO_DEPTH];

    logic              req_valid, req_fire, rsp_fire, push, pop, head_valid;
    logic [CNT_W:0]    inflight;
    logic [ADDR_W-1:0] redir_pc;

    always_comb begin
        inflight      = {1'b0, count_q} + {1'b0, outstanding_q};
        req_valid     = (state_q == ST_FETCH) && !sys_rst && (inflight < DEPTH_C);
        req_fire      = req_valid && bus.imem_req_ready;
        // A response with nothing outstanding is a protocol error and is ignored.
        rsp_fire      = bus.imem_rsp_valid && (outstanding_q != '0);
        head_valid    = (count_q != '0);
        pop           = head_valid && bus.instr_ready;
        redir_pc      = bus.redirect_pc & ~ADDR_W'(3);
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);

        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        drop_d   = drop_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        push     = 1'b0;

        if (bus.redirect_valid) begin
            // Everything still in flight after this edge is stale.
            pc_d     = redir_pc;
            rsp_pc_d = redir_pc;
            drop_d   = outstanding_d;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (req_fire) pc_d = pc_q + ADDR_W'(4);
            if (rsp_fire) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CNT_W'(1);
                end else begin
                    push     = 1'b1;
                    rsp_pc_d = rsp_pc_q + ADDR_W'(4);
                end
            end
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        state_d = (drop_d != '0) ? ST_FLUSH : ST_FETCH;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_q[i] <= '0;
                fpc_q[i]  <= '0;
            end
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            if (push) begin
                data_q[wr_ptr_q] <= bus.imem_rsp_data;
                fpc_q[wr_ptr_q]  <= rsp_pc_q;
            end
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.instr_valid    = head_valid;
    assign bus.instr          = head_valid ? data_q[rd_ptr_q] : '0;
    assign bus.instr_pc       = head_valid ? fpc_q[rd_ptr_q]  : '0;

    rsp_with_outstanding: assert property (@(posedge sys_clk) disable iff (sys_rst)
        bus.imem_rsp_valid |-> (outstanding_q != '0));
endmodule

// File: tb/tb_xfan_ifu_fetch.sv
// Bench for xfan_ifu_fetch: directed scenarios then random traffic, all checked against a
// transaction-level model (queues of in-flight requests and expected decode entries).
module tb_xfan_ifu_fetch;
    logic sys_clk = 1'b0;
    logic sys_rst;

    always #5 sys_clk = ~sys_clk;

    xfan_ifu_fetch_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

    xfan_ifu_fetch #(
        .ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    typedef struct { logic [31:0] addr; int due; }          mreq_t;
    typedef struct { logic [31:0] addr; bit stale; }        fly_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; }  ent_t;

    mreq_t       mem_q[$];
    fly_t        fly_q[$];
    ent_t        exp_q[$];
    logic [31:0] m_pc;
    int          k;
    int          last_due;
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h7F4A_7C15;
    endfunction

    function automatic int stale_cnt();
        int n = 0;
        foreach (fly_q[i]) if (fly_q[i].stale) n++;
        return n;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", tag, obs, exp, k);
        end
    endtask

    task automatic model_reset();
        mem_q.delete();
        fly_q.delete();
        exp_q.delete();
        m_pc     = 32'h0;
        last_due = -1;
    endtask

    task automatic cycle(input bit rr, input bit ir, input bit rdv, input logic [31:0] rpc,
                         input bit rst, input int lat);
        bit          exp_rv, rsp, pop, fire;
        logic [31:0] rdata, exp_instr, exp_ipc;
        fly_t        f;
        int          d;
        @(negedge sys_clk);
        sys_rst            = rst;
        bus.imem_req_ready = rr;
        bus.instr_ready    = ir;
        bus.redirect_valid = rdv;
        bus.redirect_pc    = rpc;
        rsp   = !rst && (mem_q.size() > 0) && (mem_q[0].due <= k);
        rdata = rsp ? mem_word(mem_q[0].addr) : $urandom;
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rdata;
        #1;
        exp_rv = !rst && (stale_cnt() == 0) && (exp_q.size() + fly_q.size() < 2);
        exp_instr = 32'h0;
        exp_ipc   = 32'h0;
        if (exp_q.size() > 0) begin
            exp_instr = exp_q[0].data;
            exp_ipc   = exp_q[0].pc;
        end
        check_val("req_valid",   bus.imem_req_valid, exp_rv);
        check_val("req_addr",    bus.imem_req_addr,  m_pc);
        check_val("instr_valid", bus.instr_valid,    exp_q.size() > 0);
        check_val("instr",       bus.instr,          exp_instr);
        check_val("instr_pc",    bus.instr_pc,       exp_ipc);
        @(posedge sys_clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            pop  = (exp_q.size() > 0) && ir;
            fire = exp_rv && rr;
            f    = '{addr: 32'h0, stale: 1'b1};
            if (rsp) begin
                void'(mem_q.pop_front());
                f = fly_q.pop_front();
            end
            if (fire) begin
                fly_q.push_back('{addr: m_pc, stale: 1'b0});
                d = (k + lat > last_due + 1) ? k + lat : last_due + 1;
                mem_q.push_back('{addr: m_pc, due: d});
                last_due = d;
            end
            if (pop) void'(exp_q.pop_front());
            if (rdv) begin
                foreach (fly_q[i]) fly_q[i].stale = 1'b1;
                exp_q.delete();
                m_pc = {rpc[31:2], 2'b00};
            end else begin
                if (fire) m_pc = m_pc + 32'd4;
                if (rsp && !f.stale) exp_q.push_back('{pc: f.addr, data: rdata});
            end
        end
        k++;
    endtask

    initial begin
        sys_rst            = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        k = 0;
        model_reset();
        repeat (2) @(posedge sys_clk);
        #1;
        check_val("rst_req_valid", bus.imem_req_valid, 1'b0);
        check_val("rst_addr",      bus.imem_req_addr,  32'h0);
        check_val("rst_instr_vld", bus.instr_valid,    1'b0);

        // Streaming at full rate, latency 1.
        cycle(1, 1, 0, 0, 1, 1);
        cycle(1, 1, 0, 0, 0, 1);
        check_val("t1_no_bypass", bus.instr_valid, 1'b0);
        cycle(1, 1, 0, 0, 0, 1);
        check_val("t1_first_vld", bus.instr_valid, 1'b1);
        check_val("t1_first_pc",  bus.instr_pc,    32'h0);
        check_val("t1_first_dat", bus.instr,       mem_word(32'h0));
        repeat (6) cycle(1, 1, 0, 0, 0, 1);

        // Decode stalled: credit stops fetch after two.
        cycle(1, 1, 0, 0, 1, 1);
        repeat (4) cycle(1, 0, 0, 0, 0, 1);
        check_val("t2_credit_stop", bus.imem_req_valid, 1'b0);
        check_val("t2_head_pc",     bus.instr_pc,       32'h0);
        repeat (6) cycle(1, 1, 0, 0, 0, 1);

        // Memory not ready: address held.
        cycle(1, 1, 0, 0, 1, 1);
        repeat (2) cycle(1, 1, 0, 0, 0, 1);
        cycle(0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            check_val("t3_hold_vld",  bus.imem_req_valid, 1'b1);
            check_val("t3_hold_addr", bus.imem_req_addr,  32'h8);
            cycle(0, 1, 0, 0, 0, 1);
        end
        repeat (4) cycle(1, 1, 0, 0, 0, 1);

        // Redirect with two responses in flight at latency 3.
        cycle(1, 1, 0, 0, 1, 3);
        repeat (2) cycle(1, 1, 0, 0, 0, 3);
        cycle(1, 1, 1, 32'h100, 0, 3);
        check_val("t4_flush_a", bus.imem_req_valid, 1'b0);
        cycle(1, 1, 0, 0, 0, 3);
        check_val("t4_flush_b", bus.imem_req_valid, 1'b0);
        cycle(1, 1, 0, 0, 0, 3);
        check_val("t4_resume_vld",  bus.imem_req_valid, 1'b1);
        check_val("t4_resume_addr", bus.imem_req_addr,  32'h100);
        repeat (8) cycle(1, 1, 0, 0, 0, 3);

        // Redirect coinciding with a response and an accept.
        cycle(1, 1, 0, 0, 1, 1);
        cycle(1, 1, 0, 0, 0, 1);
        cycle(1, 1, 1, 32'h203, 0, 1);
        check_val("t5_flush", bus.imem_req_valid, 1'b0);
        cycle(1, 1, 0, 0, 0, 1);
        check_val("t5_resume_addr", bus.imem_req_addr, 32'h200);
        check_val("t5_no_instr",    bus.instr_valid,   1'b0);
        repeat (6) cycle(1, 1, 0, 0, 0, 1);

        // Reset with work queued and in flight.
        cycle(1, 1, 0, 0, 1, 1);
        repeat (2) cycle(1, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 1, 1);
        check_val("t6_req_valid", bus.imem_req_valid, 1'b0);
        check_val("t6_addr",      bus.imem_req_addr,  32'h0);
        check_val("t6_instr_vld", bus.instr_valid,    1'b0);
        check_val("t6_instr",     bus.instr,          32'h0);
        check_val("t6_instr_pc",  bus.instr_pc,       32'h0);
        repeat (6) cycle(1, 1, 0, 0, 0, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 15) == 0, $urandom,
                  $urandom_range(0, 199) == 0, $urandom_range(1, 4));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
